// File: rtl/apb_pkg.sv
// Shared APB definitions: requester FSM states, bus widths and the
// register map of the I2C peripheral sitting behind the APB requester.
package apb_pkg;

  localparam int APB_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  // I2C peripheral register offsets
  localparam logic [APB_WIDTH-1:0] TX_FIFO    = 32'd0;
  localparam logic [APB_WIDTH-1:0] RX_FIFO    = 32'd4;
  localparam logic [APB_WIDTH-1:0] CONFIG     = 32'd8;
  localparam logic [APB_WIDTH-1:0] TIMEOUT    = 32'd12;
  localparam logic [APB_WIDTH-1:0] CURRENT_TX = 32'd16;

endpackage

// File: rtl/apb_requester.sv
// APB requester: turns one valid/ready command into a single APB transfer
// (SETUP then ACCESS) and returns the completion on a valid/ready response.
// Optional feature: define APB_REQUESTER_TIMEOUT_EN to abort ACCESS after
// TIMEOUT_CYCLES wait cycles with RSP_ERR and RSP_TIMEOUT set.
module apb_requester
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 CMD_VALID,
  output logic                 CMD_READY,
  input  logic                 CMD_WRITE,
  input  logic [APB_WIDTH-1:0] CMD_ADDR,
  input  logic [APB_WIDTH-1:0] CMD_WDATA,
  output logic                 RSP_VALID,
  input  logic                 RSP_READY,
  output logic [APB_WIDTH-1:0] RSP_RDATA,
  output logic                 RSP_ERR,
  output logic                 RSP_TIMEOUT,
  output logic                 PSELx,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [APB_WIDTH-1:0] PADDR,
  output logic [APB_WIDTH-1:0] PWDATA,
  input  logic [APB_WIDTH-1:0] PRDATA,
  input  logic                 PREADY,
  input  logic                 PSLVERR
);

  apb_state_t state;
  apb_state_t state_next;
  logic       timeout_hit;

  // State register; reset abandons any transfer in flight
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the state-decoded handshake / APB strobes
  always_comb begin
    state_next = state;
    CMD_READY  = 1'b0;
    RSP_VALID  = 1'b0;
    PSELx      = 1'b0;
    PENABLE    = 1'b0;
    case (state)
      IDLE: begin
        CMD_READY = 1'b1;
        if (CMD_VALID) begin
          state_next = SETUP;
        end
      end
      SETUP: begin
        PSELx      = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        PSELx   = 1'b1;
        PENABLE = 1'b1;
        if (PREADY || timeout_hit) begin
          state_next = RESP;
        end
      end
      RESP: begin
        RSP_VALID = 1'b1;
        if (RSP_READY) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Command capture and completion capture; the APB address/data/direction
  // only change on command accept so they stay quiet while PSELx is low
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      RSP_RDATA <= '0;
      RSP_ERR   <= 1'b0;
    end else begin
      if (state == IDLE && CMD_VALID) begin
        PWRITE <= CMD_WRITE;
        PADDR  <= CMD_ADDR;
        PWDATA <= CMD_WDATA;
      end
      if (state == ACCESS) begin
        if (PREADY) begin
          RSP_ERR   <= PSLVERR;
          RSP_RDATA <= PWRITE ? '0 : PRDATA;
        end else if (timeout_hit) begin
          RSP_ERR   <= 1'b1;
          RSP_RDATA <= '0;
        end
      end
    end
  end

`ifdef APB_REQUESTER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wait_cnt;
  logic        rsp_timeout_q;

  // A completer answering on the limit cycle still wins over the abort
  assign timeout_hit = (state == ACCESS) && !PREADY && (wait_cnt == TIMEOUT_LIMIT);
  assign RSP_TIMEOUT = rsp_timeout_q;

  // Wait counter restarts every transfer and counts stalled ACCESS cycles
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wait_cnt      <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      if (state == SETUP) begin
        wait_cnt <= '0;
      end else if (state == ACCESS && !PREADY) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
      if (state == ACCESS) begin
        if (PREADY) begin
          rsp_timeout_q <= 1'b0;
        end else if (timeout_hit) begin
          rsp_timeout_q <= 1'b1;
        end
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign RSP_TIMEOUT = 1'b0;
`endif

endmodule

// File: doc/apb_requester.md
APB_REQUESTER -- requirements
Module: apb_requester

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, meaning the number of ACCESS wait cycles allowed before abort (range 2..65535).
REQ-002 SHALL have port PCLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 SHALL have port PRESET, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have command ports CMD_VALID (input, 1), CMD_READY (output, 1), CMD_WRITE (input, 1), CMD_ADDR (input, 32) and CMD_WDATA (input, 32), forming the valid/ready transfer request.
REQ-005 SHALL have response ports RSP_VALID (output, 1), RSP_READY (input, 1), RSP_RDATA (output, 32), RSP_ERR (output, 1) and RSP_TIMEOUT (output, 1), forming the valid/ready completion.
REQ-006 SHALL have APB ports PSELx, PENABLE and PWRITE (outputs, 1 bit each), PADDR and PWDATA (outputs, 32 bits each), and PRDATA (input, 32), PREADY (input, 1), PSLVERR (input, 1).

Function
REQ-007 SHALL implement an FSM with states IDLE, SETUP, ACCESS and RESP.
REQ-008 In IDLE, CMD_READY SHALL be 1; in all other states it SHALL be 0.
REQ-009 In IDLE, CMD_VALID=1 SHALL register CMD_WRITE, CMD_ADDR and CMD_WDATA, then go to SETUP.
REQ-010 In SETUP (exactly 1 cycle), the outputs SHALL be PSELx=1 and PENABLE=0, with PADDR, PWRITE and PWDATA driven from the registered command; the FSM then goes to ACCESS.
REQ-011 In ACCESS, the outputs SHALL be PSELx=1 and PENABLE=1, with PADDR, PWRITE and PWDATA held stable; the FSM stays in ACCESS while PREADY=0.
REQ-012 In ACCESS with PREADY=1, the block SHALL:
- capture PSLVERR into RSP_ERR;
- capture PRDATA into RSP_RDATA for reads, or 0 for writes;
- clear RSP_TIMEOUT;
- go to RESP.
REQ-013 In RESP, RSP_VALID SHALL be 1, PSELx=0 and PENABLE=0, and RSP_* SHALL stay stable until RSP_READY=1.
REQ-014 In RESP with RSP_READY=1, the FSM SHALL go to IDLE.
REQ-015 Minimum command-accept to RSP_VALID latency SHALL be 3 cycles (IDLE, SETUP, ACCESS with PREADY=1), and the minimum issue interval SHALL be 4 cycles.
REQ-016 In IDLE and RESP, PADDR, PWDATA and PWRITE SHALL hold their last values, so that they do not toggle while PSELx=0.
REQ-017 PSLVERR and PRDATA SHALL be sampled only in ACCESS when PREADY=1 and ignored otherwise.
REQ-018 CMD_VALID asserted while CMD_READY=0 SHALL be ignored and not queued; the command is accepted only by the IDLE handshake.
REQ-019 RSP_READY asserted while not in RESP SHALL have no effect.

Reset
REQ-020 PRESET=1 at a clock edge SHALL force IDLE from any state, including mid-ACCESS, dropping PSELx and PENABLE in the next cycle and discarding the transfer without a response.
REQ-021 Reset values SHALL be:
- PSELx, PENABLE, PWRITE, RSP_VALID, RSP_ERR, RSP_TIMEOUT = 0;
- PADDR, PWDATA, RSP_RDATA = 0;
- wait counter = 0;
- CMD_READY = 1 after reset is released.

Configuration
REQ-022 With macro APB_REQUESTER_TIMEOUT_EN defined, a 16-bit wait counter SHALL clear on entering ACCESS and increment each ACCESS cycle with PREADY=0.
REQ-023 With APB_REQUESTER_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES-1 and PREADY=0, the FSM SHALL go to RESP with RSP_ERR=1, RSP_TIMEOUT=1 and RSP_RDATA=0.
REQ-024 With APB_REQUESTER_TIMEOUT_EN defined, if PREADY=1 on the same cycle the counter reaches its limit, the FSM SHALL complete normally with no timeout.
REQ-025 Without APB_REQUESTER_TIMEOUT_EN, the counter SHALL not exist, ACCESS SHALL wait indefinitely, and RSP_TIMEOUT SHALL be tied to 0.

Structure
REQ-026 Shared package apb_pkg SHALL hold:
- the state enum (IDLE, SETUP, ACCESS, RESP);
- the APB address and data width constant (32);
- the I2C peripheral address constants: TX_FIFO=0, RX_FIFO=4, CONFIG=8, TIMEOUT=12, CURRENT_TX=16.
REQ-027 The block SHALL be a single module with no sub-modules; the timeout counter is inline under the macro.

Verification
REQ-028 Write with zero wait: CMD write addr 8, data 0x0000_1234, completer PREADY=1 immediately -> one SETUP and one ACCESS cycle, PADDR=8, PWRITE=1, PWDATA=0x1234; RSP_VALID 3 cycles after accept; RSP_ERR=0.
REQ-029 Read with waits: read addr 4, PREADY low for 5 cycles, PRDATA=0x0000_00A5 -> PENABLE high for 6 cycles; RSP_RDATA=0xA5; all P* outputs stable throughout ACCESS.
REQ-030 Slave error: write addr 0 returning PSLVERR=1 with PREADY=1 -> RSP_ERR=1, RSP_TIMEOUT=0.
REQ-031 Response backpressure: RSP_READY low for 4 cycles -> RSP_* held stable, CMD_READY=0, a new CMD_VALID is not accepted; accepted the cycle after return to IDLE.
REQ-032 Timeout (macro on, TIMEOUT_CYCLES=8, PREADY stuck 0) -> RESP after 8 ACCESS cycles with RSP_ERR=1, RSP_TIMEOUT=1, RSP_RDATA=0; with macro off -> still in ACCESS after 1000 cycles.
REQ-033 Reset mid-ACCESS: assert PRESET during ACCESS -> next cycle PSELx=0, PENABLE=0, IDLE, no RSP_VALID pulse.
